// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin two-master arbiter sharing one data_bus access path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_rw,
   input  logic [63:0] m0_addr,
   input  logic [63:0] m0_wdata,
   output logic        m0_ack,
   output logic [63:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_rw,
   input  logic [63:0] m1_addr,
   input  logic [63:0] m1_wdata,
   output logic        m1_ack,
   output logic [63:0] m1_rdata,
   output logic        m1_err,
   output logic        busy,
   output logic        bus_rw,
   output logic [63:0] bus_addr,
   output logic [63:0] bus_write,
   input  logic [63:0] bus_read,
   input  logic        bus_exception
);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_ACCESS   = 2'd1;
   localparam logic [1:0] c_RESP     = 2'd2;
   localparam logic [3:0] c_CNT_INIT = 4'(MEM_LAT - 1);

   logic [1:0]  r_state;
   logic        r_last;
   logic        r_win;
   logic        r_first;
   logic        r_rw;
   logic [3:0]  r_cnt;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [63:0] r_m0_rdata;
   logic [63:0] r_m1_rdata;
   logic        r_m0_err;
   logic        r_m1_err;

   logic        w_any_req;
   logic        w_pick;
   logic        w_access;

   // On a tie the master that did not win last time is served.
   assign w_any_req = m0_req | m1_req;
   assign w_pick    = (m0_req & m1_req) ? ~r_last : m1_req;
   assign w_access  = (r_state == c_ACCESS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_IDLE;
         r_last     <= 1'b1;
         r_win      <= 1'b0;
         r_first    <= 1'b0;
         r_rw       <= 1'b0;
         r_cnt      <= 4'd0;
         r_addr     <= 64'd0;
         r_wdata    <= 64'd0;
         r_m0_rdata <= 64'd0;
         r_m1_rdata <= 64'd0;
         r_m0_err   <= 1'b0;
         r_m1_err   <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_any_req) begin
                  r_win   <= w_pick;
                  r_last  <= w_pick;
                  r_rw    <= w_pick ? m1_rw    : m0_rw;
                  r_addr  <= w_pick ? m1_addr  : m0_addr;
                  r_wdata <= w_pick ? m1_wdata : m0_wdata;
                  r_cnt   <= c_CNT_INIT;
                  r_first <= 1'b1;
                  r_state <= c_ACCESS;
               end
            end
            c_ACCESS: begin
               r_first <= 1'b0;
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  if (r_win) begin
                     r_m1_rdata <= bus_read;
                     r_m1_err   <= bus_exception;
                  end else begin
                     r_m0_rdata <= bus_read;
                     r_m0_err   <= bus_exception;
                  end
                  r_state <= c_RESP;
               end
            end
            c_RESP: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Write strobe only in the first access cycle: one write edge per transfer.
   assign bus_rw    = w_access & r_first & r_rw;
   assign bus_addr  = w_access ? r_addr  : 64'd0;
   assign bus_write = w_access ? r_wdata : 64'd0;

   assign busy      = (r_state != c_IDLE);
   assign m0_ack    = (r_state == c_RESP) & ~r_win;
   assign m1_ack    = (r_state == c_RESP) &  r_win;
   assign m0_rdata  = r_m0_rdata;
   assign m1_rdata  = r_m1_rdata;
   assign m0_err    = r_m0_err;
   assign m1_err    = r_m1_err;

endmodule

`default_nettype wire
